// File: rtl/instr_encoder.sv
// instr_encoder: encodes instruction requests into 32-bit MIPS-style words,
// queues them in a small buffer and streams them to instruction memory at
// consecutive word addresses until MAX_WORDS words have been written.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 4,
    parameter int          MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_kind,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [25:0] in_imm,
    output logic        imem_we,
    input  logic        imem_ready,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wd,
    output logic        done,
    output logic        err
);

    // Pointer, occupancy and word-count widths; counts must be able to hold
    // their maximum value, not just index below it.
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(MAX_WORDS + 1);
    localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);
    localparam logic [CW-1:0] MAX_C   = CW'(MAX_WORDS);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [CW-1:0] acc_cnt_q, acc_cnt_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic          err_q, err_d;

    logic [31:0]   buf_mem [DEPTH];
    logic [31:0]   enc_word;
    logic          kind_legal;
    logic          accept;
    logic          push;
    logic          pop;

    // Instruction encoder: R-type, I-type and jump formats; codes 10-15 are illegal.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
        enc_word   = '0;
        kind_legal = 1'b1;
        case (in_kind)
            4'd0:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h20};
            4'd1:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h22};
            4'd2:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h24};
            4'd3:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h25};
            4'd4:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h2A};
            4'd5:    enc_word = {6'h23, in_rs, in_rt, in_imm[15:0]};
            4'd6:    enc_word = {6'h2B, in_rs, in_rt, in_imm[15:0]};
            4'd7:    enc_word = {6'h04, in_rs, in_rt, in_imm[15:0]};
            4'd8:    enc_word = {6'h08, in_rs, in_rt, in_imm[15:0]};
            4'd9:    enc_word = {6'h02, in_imm};
            default: kind_legal = 1'b0;
        endcase
    end

    // Handshake outputs decode registered state only, so a pop on a full
    // buffer does not open in_ready in the same cycle.
    assign in_ready  = (state_q == ST_LOAD) && (occ_q < DEPTH_C) && (acc_cnt_q < MAX_C);
    assign imem_we   = (state_q == ST_LOAD) && (occ_q != '0);
    assign imem_wd   = buf_mem[rd_ptr_q];
    assign imem_addr = addr_q;
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;

    assign accept = in_valid & in_ready;
    assign push   = accept & kind_legal;
    assign pop    = imem_we & imem_ready;

    // Next-state computation for the buffer, counters, address and FSM.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        acc_cnt_d = acc_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        addr_d    = addr_q;
        err_d     = err_q;

        if (push) begin
            wr_ptr_d  = wr_ptr_q + PW'(1);
            acc_cnt_d = acc_cnt_q + CW'(1);
        end
        if (accept && !kind_legal) begin
            err_d = 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            wr_cnt_d = wr_cnt_q + CW'(1);
            addr_d   = addr_q + 32'd4;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
        if (state_q == ST_LOAD && wr_cnt_d == MAX_C) begin
            state_d = ST_DONE;
        end
    end

    // Control state with synchronous reset; reset discards any buffered words.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (reset) begin
            state_q   <= ST_LOAD;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            acc_cnt_q <= '0;
            wr_cnt_q  <= '0;
            addr_q    <= BASE_ADDR;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            acc_cnt_q <= acc_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
        end
    end

    // Buffer storage: the encoded word lands in the slot at the write pointer.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; occupancy and pointers alone decide which entries are valid.
        if (push) begin
            buf_mem[wr_ptr_q] <= enc_word;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized
// traffic compared cycle by cycle against a queue-based reference model.
module tb_instr_encoder;

    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          DEPTH = 4;
    localparam int          MAX   = 8;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_kind;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [25:0] in_imm;
    logic        imem_we;
    logic        imem_ready;
    logic [31:0] imem_addr;
    logic [31:0] imem_wd;
    logic        done;
    logic        err;

    instr_encoder #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH),
        .MAX_WORDS (MAX)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_imm     (in_imm),
        .imem_we    (imem_we),
        .imem_ready (imem_ready),
        .imem_addr  (imem_addr),
        .imem_wd    (imem_wd),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of pending words plus counters.
    logic [31:0] m_q [$];
    int          m_acc;
    int          m_wr;
    bit          m_err;
    bit          m_done;
    logic [31:0] m_addr;

    // Log of writes actually completed by the DUT.
    logic [31:0] wlog [$];
    logic [31:0] alog [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Encoding computed from the field layout with plain arithmetic.
    function automatic logic [31:0] ref_encode(input int kind, input int rs, input int rt,
                                               input int rd, input int imm);
        int     funct_tab [5] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A};
        int     op_tab    [4] = '{32'h23, 32'h2B, 32'h04, 32'h08};
        longint w;
        if (kind <= 4)
            w = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048
                + longint'(funct_tab[kind]);
        else if (kind <= 8)
            w = longint'(op_tab[kind-5]) * 67108864 + longint'(rs) * 2097152
                + longint'(rt) * 65536 + longint'(imm % 65536);
        else
            w = longint'(2) * 67108864 + longint'(imm % 67108864);
        return w[31:0];
    endfunction

    // One cycle: drive inputs at the falling edge, check outputs against the
    // model, advance the model, then move to the next falling edge.
    task automatic step(input bit v, input int kind, input int rs, input int rt, input int rd,
                        input int imm, input bit rdy, output bit acc);
        bit exp_ready;
        bit exp_we;
        in_valid   = v;
        in_kind    = 4'(kind);
        in_rs      = 5'(rs);
        in_rt      = 5'(rt);
        in_rd      = 5'(rd);
        in_imm     = 26'(imm);
        imem_ready = rdy;
        #1;
        exp_ready = !m_done && (m_q.size() < DEPTH) && (m_acc < MAX);
        exp_we    = !m_done && (m_q.size() != 0);
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("imem_we", 32'(imem_we), 32'(exp_we));
        check("imem_addr", imem_addr, m_addr);
        check("done", 32'(done), 32'(m_done));
        check("err", 32'(err), 32'(m_err));
        if (exp_we) check("imem_wd", imem_wd, m_q[0]);
        acc = v && in_ready;
        if (imem_we && rdy) begin
            wlog.push_back(imem_wd);
            alog.push_back(imem_addr);
        end
        if (exp_we && rdy) begin
            void'(m_q.pop_front());
            m_addr = m_addr + 32'd4;
            m_wr++;
            if (m_wr == MAX) m_done = 1'b1;
        end
        if (v && exp_ready) begin
            if (kind <= 9) begin
                m_q.push_back(ref_encode(kind, rs, rt, rd, imm));
                m_acc++;
            end else begin
                m_err = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit rdy);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 0, 0, rdy, a);
    endtask

    task automatic do_reset(input bit rdy);
        reset      = 1'b1;
        in_valid   = 1'b0;
        imem_ready = rdy;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_q.delete();
        wlog.delete();
        alog.delete();
        m_acc  = 0;
        m_wr   = 0;
        m_err  = 1'b0;
        m_done = 1'b0;
        m_addr = BASE;
    endtask

    initial begin
        bit a;
        int idx;
        int cyc;
        int t3_kind [6] = '{0, 1, 2, 3, 4, 0};

        in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;

        // Reset state and first word.
        do_reset(1'b1);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_addr", imem_addr, BASE);
        step(1'b1, 0, 1, 2, 3, 0, 1'b1, a);
        check("add_we", 32'(imem_we), 32'd1);
        check("add_wd", imem_wd, 32'h0022_1820);
        check("add_addr", imem_addr, BASE);
        idle(1, 1'b1);
        check("add_next_addr", imem_addr, BASE + 32'd4);

        // Known I-type and jump encodings at consecutive addresses.
        do_reset(1'b1);
        step(1'b1, 5, 0, 8, 0, 4, 1'b1, a);
        step(1'b1, 7, 1, 2, 0, 32'hFFFF, 1'b1, a);
        step(1'b1, 8, 0, 2, 0, 5, 1'b1, a);
        step(1'b1, 9, 0, 0, 0, 32'h10, 1'b1, a);
        idle(4, 1'b1);
        check("seq_nwrites", 32'(wlog.size()), 32'd4);
        if (wlog.size() >= 4) begin
            check("seq_lw", wlog[0], 32'h8C08_0004);
            check("seq_beq", wlog[1], 32'h1022_FFFF);
            check("seq_addi", wlog[2], 32'h2002_0005);
            check("seq_j", wlog[3], 32'h0800_0010);
            for (int i = 0; i < 4; i++) check("seq_addr", alog[i], BASE + 32'(4 * i));
        end

        // Back-pressure: buffer fills at DEPTH, then drains and takes the rest.
        do_reset(1'b0);
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, t3_kind[idx], idx, idx + 1, idx + 2, 0, 1'b0, a);
            if (a) idx++;
        end
        check("bp_accepted", 32'(idx), 32'd4);
        check("bp_ready_low", 32'(in_ready), 32'd0);
        check("bp_no_write", 32'(wlog.size()), 32'd0);
        cyc = 0;
        while ((idx < 6 || m_q.size() != 0) && cyc < 40) begin
            step(idx < 6, t3_kind[idx % 6], idx, idx + 1, idx + 2, 0, 1'b1, a);
            if (a) idx++;
            cyc++;
        end
        check("bp_all_accepted", 32'(idx), 32'd6);
        check("bp_writes", 32'(wlog.size()), 32'd6);

        // Illegal kind: error flag, no write, address unchanged.
        do_reset(1'b1);
        step(1'b1, 12, 3, 4, 5, 0, 1'b1, a);
        idle(2, 1'b1);
        check("ill_err", 32'(err), 32'd1);
        check("ill_no_write", 32'(wlog.size()), 32'd0);
        check("ill_addr", imem_addr, BASE);
        step(1'b1, 1, 4, 5, 6, 0, 1'b1, a);
        idle(3, 1'b1);
        check("ill_next_writes", 32'(wlog.size()), 32'd1);
        if (wlog.size() >= 1) check("ill_next_addr", alog[0], BASE);
        check("ill_err_sticky", 32'(err), 32'd1);

        // Reset with buffered words stalled: nothing stale is written afterwards.
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 3, i, i, i, 0, 1'b0, a);
        check("rst_mid_we_before", 32'(imem_we), 32'd1);
        do_reset(1'b0);
        check("rst_mid_we_after", 32'(imem_we), 32'd0);
        idle(4, 1'b1);
        check("rst_mid_no_stale", 32'(wlog.size()), 32'd0);

        // Randomized traffic up to MAX_WORDS, then terminal state and reset.
        for (int round = 0; round < 4; round++) begin
            do_reset(1'b1);
            cyc = 0;
            while (!m_done && cyc < 600) begin
                step($urandom_range(0, 9) < 7, $urandom_range(0, 15), $urandom_range(0, 31),
                     $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 32'h3FF_FFFF), $urandom_range(0, 9) < 6, a);
                cyc++;
            end
            check("rand_reached_done", 32'(m_done), 32'd1);
            step(1'b1, 0, 1, 1, 1, 0, 1'b1, a);
            check("rand_done", 32'(done), 32'd1);
            check("rand_nwrites", 32'(wlog.size()), 32'(MAX));
            check("rand_final_addr", imem_addr, BASE + 32'(4 * MAX));
            do_reset(1'b1);
            check("rand_rst_done", 32'(done), 32'd0);
            check("rand_rst_addr", imem_addr, BASE);
            check("rand_rst_ready", 32'(in_ready), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
